// File: rtl/rc_sched_pkg.sv
// Shared types and sizing for the Reinforced Concrete batch scheduler.
// Default sizing matches 13 lanes of 3-element states per slot.
package rc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_PAD,
    S_RUN,
    S_DRAIN,
    S_ABORT
  } state_t;

  localparam int SLOT_WORDS = 39;
  localparam int JOB_WORDS  = 2 * SLOT_WORDS;
  localparam int CNT_W      = $clog2(JOB_WORDS + 1);

  // Word index to one-hot slot strobe: first slot_words go to slot 0.
  function automatic logic [1:0] slot_onehot(input int idx, input int slot_words);
    return (idx < slot_words) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/rc_sched_out_fifo.sv
// Two-entry output FIFO holding {last, data} words read back from the core.
// Pushes into a full FIFO without a simultaneous pop are ignored.
module rc_sched_out_fifo #(
  parameter int W = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_pop;
  logic       w_push;

  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;
  assign w_pop   = i_pop & o_valid;
  assign w_push  = i_push & ((r_count != 2'd2) | w_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [W-1:0] r_entry;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          r_entry <= '0;
        else if (w_push && (r_wr_ptr == 1'(gi)))
          r_entry <= i_din;
      end
    end
  endgenerate

  assign o_dout = r_rd_ptr ? g_entry[1].r_entry : g_entry[0].r_entry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/rc_batch_scheduler.sv
// Loads a 78-word job into the dual-slot permutation core, runs it, drains it.
// Define RC_SCHED_TIMEOUT_EN to abort a RUN that exceeds TIMEOUT_CYCLES.
module rc_batch_scheduler
  import rc_sched_pkg::*;
#(
  parameter int N_BITS         = 254,
  parameter int STATE_SIZE     = 3,
  parameter int LANES          = 13,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [N_BITS-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_BITS-1:0] m_data,
  output logic              m_last,
  output logic              core_reset,
  output logic [1:0]        core_wr,
  output logic [1:0]        core_rd,
  output logic [N_BITS-1:0] core_in,
  output logic              core_enable,
  input  logic [N_BITS-1:0] core_out,
  input  logic              core_done,
  output logic              busy,
  output logic              err
);

  localparam int L_SLOT = STATE_SIZE * LANES;
  localparam int L_JOB  = 2 * L_SLOT;
  localparam int L_CW   = $clog2(L_JOB + 1);

  state_t          r_state, w_next;
  logic [L_CW-1:0] r_cnt;
  logic [L_CW-1:0] r_rd_cnt;
  logic            r_inflight;
  logic            r_inflight_last;
  logic [N_BITS:0] w_fifo_dout;
  logic            w_fifo_valid;
  logic [1:0]      w_fifo_count;
  logic            w_pop;
  logic [2:0]      w_occ_next;
  logic            w_can_read;
  logic [1:0]      w_slot_wr;
  logic [1:0]      w_slot_rd;

  assign w_slot_wr = slot_onehot(int'(r_cnt), L_SLOT);
  assign w_slot_rd = slot_onehot(int'(r_rd_cnt), L_SLOT);
  assign w_pop     = w_fifo_valid & m_ready;

  // Occupancy after this cycle's pop plus the read still in flight must leave room.
  assign w_occ_next = {1'b0, w_fifo_count} - {2'b0, w_pop} + {2'b0, r_inflight};
  assign w_can_read = (r_state == S_DRAIN) && (r_rd_cnt < L_CW'(L_JOB)) && (w_occ_next < 3'd2);

`ifdef RC_SCHED_TIMEOUT_EN
  localparam int L_RW = $clog2(TIMEOUT_CYCLES + 1);
  logic [L_RW-1:0] r_run_cnt;
  logic            r_err;
`endif

  always_comb begin
    w_next      = r_state;
    s_ready     = 1'b0;
    core_wr     = 2'b00;
    core_rd     = 2'b00;
    core_in     = '0;
    core_enable = 1'b0;
    case (r_state)
      S_IDLE:  if (s_valid) w_next = S_CLR;
      S_CLR:   w_next = S_LOAD;
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          core_wr = w_slot_wr;
          core_in = s_data;
          if (r_cnt == L_CW'(L_JOB - 1)) w_next = S_RUN;
          else if (s_last)               w_next = S_PAD;
        end
      end
      S_PAD: begin
        core_wr = w_slot_wr;
        if (r_cnt == L_CW'(L_JOB - 1)) w_next = S_RUN;
      end
      S_RUN: begin
        core_enable = 1'b1;
        if (core_done) w_next = S_DRAIN;
`ifdef RC_SCHED_TIMEOUT_EN
        else if (r_run_cnt == L_RW'(TIMEOUT_CYCLES - 1)) w_next = S_ABORT;
`endif
      end
      S_DRAIN: begin
        if (w_can_read) core_rd = w_slot_rd;
        if (w_pop && w_fifo_dout[N_BITS]) w_next = S_IDLE;
      end
      S_ABORT: w_next = s_valid ? S_CLR : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_rd_cnt        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLR)      r_cnt <= '0;
      else if (core_wr != 2'b00) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_CLR)      r_rd_cnt <= '0;
      else if (core_rd != 2'b00) r_rd_cnt <= r_rd_cnt + 1'b1;
      r_inflight      <= (core_rd != 2'b00);
      r_inflight_last <= (core_rd != 2'b00) && (r_rd_cnt == L_CW'(L_JOB - 1));
    end
  end

`ifdef RC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_run_cnt <= (r_state == S_RUN) ? r_run_cnt + 1'b1 : '0;
      if (r_state == S_RUN && w_next == S_ABORT) r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  rc_sched_out_fifo #(.W(N_BITS + 1)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_inflight),
    .i_din   ({r_inflight_last, core_out}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign m_valid    = w_fifo_valid;
  assign m_data     = w_fifo_dout[N_BITS-1:0];
  assign m_last     = w_fifo_dout[N_BITS];
  assign busy       = (r_state != S_IDLE);
  assign core_reset = ~reset_n | (r_state == S_CLR);

endmodule

// File: tb/tb_rc_batch_scheduler.sv
// Directed bench for rc_batch_scheduler with a behavioural dual-slot core model.
// The abort scenario runs only when RC_SCHED_TIMEOUT_EN is defined.
module tb_rc_batch_scheduler;
  import rc_sched_pkg::*;

  localparam int N = 254;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         s_valid, s_ready, s_last;
  logic [N-1:0] s_data;
  logic         m_valid, m_ready, m_last;
  logic [N-1:0] m_data;
  logic         core_reset, core_enable, core_done, busy, err;
  logic [1:0]   core_wr, core_rd;
  logic [N-1:0] core_in;
  logic [N-1:0] core_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rc_batch_scheduler #(
    .N_BITS(N), .STATE_SIZE(3), .LANES(13), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_reset(core_reset), .core_wr(core_wr), .core_rd(core_rd),
    .core_in(core_in), .core_enable(core_enable), .core_out(core_out),
    .core_done(core_done), .busy(busy), .err(err)
  );

  // Core model: identity permutation, done after done_dly enabled cycles.
  logic [N-1:0] cmem [JOB_WORDS];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0, run_cnt = 0;
  int done_dly = 20;

  always @(posedge clk) begin
    if (core_reset) begin
      wp0 <= 0; wp1 <= 0; rp0 <= 0; rp1 <= 0; run_cnt <= 0;
      core_out <= '0;
    end else begin
      if (core_wr[0] && wp0 < SLOT_WORDS) begin cmem[wp0] <= core_in; wp0 <= wp0 + 1; end
      if (core_wr[1] && wp1 < SLOT_WORDS) begin cmem[SLOT_WORDS + wp1] <= core_in; wp1 <= wp1 + 1; end
      if (core_rd[0] && rp0 < SLOT_WORDS) begin core_out <= cmem[rp0]; rp0 <= rp0 + 1; end
      if (core_rd[1] && rp1 < SLOT_WORDS) begin core_out <= cmem[SLOT_WORDS + rp1]; rp1 <= rp1 + 1; end
      if (core_enable) run_cnt <= run_cnt + 1;
    end
  end
  assign core_done = (run_cnt >= done_dly);

  task automatic check_val(input string tag, input logic [N:0] got, input logic [N:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".s_ready"}, s_ready, 0);
    check_val({tag, ".m_valid"}, m_valid, 0);
    check_val({tag, ".m_data"}, m_data, 0);
    check_val({tag, ".m_last"}, m_last, 0);
    check_val({tag, ".core_wr"}, core_wr, 0);
    check_val({tag, ".core_rd"}, core_rd, 0);
    check_val({tag, ".core_in"}, core_in, 0);
    check_val({tag, ".core_enable"}, core_enable, 0);
    check_val({tag, ".busy"}, busy, 0);
    check_val({tag, ".err"}, err, 0);
    check_val({tag, ".core_reset"}, core_reset, 1);
  endtask

  // Full job: n_data words from base (s_last on the last one when use_last),
  // mode 1 toggles m_ready 1-0-0-1; hold_next keeps s_valid high afterwards.
  task automatic run_job(input string name, input int base, input int n_data,
                         input bit use_last, input int mode, input bit hold_next);
    logic [N-1:0] exp_w [JOB_WORDS];
    logic [N:0]   prev_out = '0;
    bit           prev_stall = 0, seen_rd = 0;
    int           sent = 0, wr_idx = 0, out_idx = 0, cyc = 0;
    for (int i = 0; i < JOB_WORDS; i++) exp_w[i] = (i < n_data) ? N'(base + i) : '0;
    done_dly = 20;
    while (out_idx < JOB_WORDS && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (sent < n_data) begin
        s_valid = 1'b1; s_data = N'(base + sent); s_last = use_last && (sent == n_data - 1);
      end else if (hold_next) begin
        s_valid = 1'b1; s_data = N'(base + 100); s_last = 1'b0;
      end else begin
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      end
      m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      #1;
      if (prev_stall) begin
        check_val({name, ".hold_valid"}, m_valid, 1);
        check_val({name, ".hold_data"}, {m_last, m_data}, prev_out);
      end
      if (mode != 0) check_val({name, ".fifo_occ_le2"}, (dut.w_fifo_count > 2'd2), 0);
      if (core_wr != 2'b00) begin
        check_val({name, ".wr_slot"}, core_wr, (wr_idx < SLOT_WORDS) ? 1 : 2);
        check_val({name, ".wr_data"}, core_in, exp_w[wr_idx]);
        check_val({name, ".wr_rd_excl"}, core_rd, 0);
        check_val({name, ".wr_in_drain"}, seen_rd, 0);
        if (wr_idx >= n_data) check_val({name, ".pad_ready"}, s_ready, 0);
        wr_idx++;
      end
      if (core_rd != 2'b00) seen_rd = 1;
      if (s_valid && s_ready) sent++;
      if (m_valid && m_ready) begin
        check_val({name, ".out"}, {m_last, m_data}, {out_idx == JOB_WORDS - 1, exp_w[out_idx]});
        out_idx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_last, m_data};
    end
    check_val({name, ".wr_count"}, wr_idx, JOB_WORDS);
    check_val({name, ".out_count"}, out_idx, JOB_WORDS);
    check_val({name, ".err"}, err, 0);
    $display("job %s: sent=%0d written=%0d out=%0d cycles=%0d", name, sent, wr_idx, out_idx, cyc);
  endtask

  // Push a full 78-word job without s_last and stop at the first RUN cycle.
  task automatic load_only(input string name, input int base);
    int sent = 0, cyc = 0;
    while (sent < JOB_WORDS && cyc < 300) begin
      @(negedge clk);
      cyc++;
      s_valid = 1'b1; s_data = N'(base + sent); s_last = 1'b0;
      #1;
      if (s_ready) sent++;
    end
    @(negedge clk);
    s_valid = 1'b0; s_data = '0;
    #1;
    check_val({name, ".load_count"}, sent, JOB_WORDS);
    check_val({name, ".run_enable"}, core_enable, 1);
    $display("job %s: loaded %0d words in %0d cycles", name, sent, cyc);
  endtask

  initial begin
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_val("idle.core_reset", core_reset, 0);
    check_val("idle.busy", busy, 0);

    run_job("seq", 1, JOB_WORDS, 1'b0, 0, 1'b0);
    @(negedge clk); #1;
    check_val("seq.busy_after", busy, 0);

    run_job("pad", 1, 5, 1'b1, 0, 1'b0);
    @(negedge clk); #1;
    check_val("pad.busy_after", busy, 0);

    run_job("bp", 300, JOB_WORDS, 1'b0, 1, 1'b0);
    @(negedge clk); #1;
    check_val("bp.busy_after", busy, 0);

    run_job("b2b_a", 400, JOB_WORDS, 1'b0, 0, 1'b1);
    @(negedge clk); #1;
    check_val("b2b.idle_gap", busy, 0);
    @(negedge clk); #1;
    check_val("b2b.clr", core_reset, 1);
    check_val("b2b.clr_busy", busy, 1);
    run_job("b2b_b", 500, JOB_WORDS, 1'b0, 0, 1'b0);
    @(negedge clk); #1;
    check_val("b2b.busy_after", busy, 0);

    done_dly = 1 << 30;
    load_only("rst", 600);
    repeat (3) @(negedge clk);
    #1;
    check_val("rst.busy_pre", busy, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk); #1;
    check_val("rst_mid.core_reset_hold", core_reset, 1);
    reset_n = 1'b1;
    run_job("after_rst", 700, JOB_WORDS, 1'b0, 0, 1'b0);

`ifdef RC_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      bit saw_mv = 0;
      done_dly = 1 << 30;
      load_only("tmo", 800);
      while (core_enable && n < 100) begin
        n++;
        @(negedge clk); #1;
        if (m_valid) saw_mv = 1;
      end
      check_val("tmo.run_cycles", n, 16);
      check_val("tmo.err_set", err, 1);
      check_val("tmo.abort_busy", busy, 1);
      repeat (5) begin
        @(negedge clk); #1;
        if (m_valid) saw_mv = 1;
      end
      check_val("tmo.err_sticky", err, 1);
      check_val("tmo.idle", busy, 0);
      check_val("tmo.no_mvalid", saw_mv, 0);
      $display("job tmo: aborted after %0d run cycles", n);
    end
`else
    @(negedge clk); #1;
    check_val("no_tmo.err", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc_batch_scheduler.md
# rc_batch_scheduler

Sequencer for the dual-slot Reinforced Concrete permutation core wrapper. It accepts a valid/ready stream of field elements and packs them into two 39-word slots: 13 lanes × STATE_SIZE elements, slot 0 then slot 1. It then runs the permutation and drains both slots back out as a valid/ready stream. It sits between the host stream fabric and the core wrapper, and owns all of the wrapper's write, read, enable and reset strobes.

## Interface
Parameters:
- N_BITS, 254, field element width
- STATE_SIZE, 3, elements per permutation state
- LANES, 13, states per slot
- TIMEOUT_CYCLES, 4096, maximum cycles in RUN before abort (used only when RC_SCHED_TIMEOUT_EN is defined)

Ports:
- clk  in  1  clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  scheduler accepts input word
- s_data  in  N_BITS  input element
- s_last  in  1  final word of job; remaining slot words are zero-padded
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts output word
- m_data  out  N_BITS  output element
- m_last  out  1  marks the 78th output word
- core_reset  out  1  synchronous active-high clear to core wrapper
- core_wr  out  2  one-hot slot write strobe
- core_rd  out  2  one-hot slot read strobe
- core_in  out  N_BITS  word written to core
- core_enable  out  1  permutation run enable
- core_out  in  N_BITS  core read data, registered, valid 1 cycle after core_rd
- core_done  in  1  permutation complete (level)
- busy  out  1  state ≠ IDLE
- err  out  1  sticky timeout flag

## Operation
- SLOT_WORDS = STATE_SIZE*LANES = 39; JOB_WORDS = 78. Word index i goes to slot i/39, position i%39.
- States: IDLE, CLR, LOAD, PAD, RUN, DRAIN, ABORT.
- IDLE: s_ready=0. Transitions to CLR when s_valid=1.
- CLR: core_reset=1 for exactly one cycle; word counter cleared; goes to LOAD.
- LOAD: s_ready=1. On each handshake: core_wr one-hot selects the slot, core_in=s_data, counter increments.
  - Counter reaching 78 → RUN.
  - s_last with counter<78 → PAD; the s_last word itself is written.
  - s_last on word 78 → RUN.
- PAD: s_ready=0. Writes zero every cycle until counter=78, then → RUN.
- RUN: core_enable=1. On the first cycle core_done=1 → DRAIN; core_enable is 0 from the next cycle.
- DRAIN:
  - Issues core_rd for slot 0 positions 0..38, then slot 1 positions 0..38.
  - Read data lands in a 2-entry output FIFO.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2.
  - After the 78th word pops → IDLE.
- core_wr and core_rd are never asserted together, and never asserted outside LOAD, PAD and DRAIN.
- Input words presented while not in LOAD are held: s_ready=0, nothing is dropped.
- s_valid without s_last after word 78: that word starts the next job.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, core_wr=0, core_rd=0, core_in=0, core_enable=0, busy=0, err=0, state=IDLE.
- core_reset = (~reset_n) | (state==CLR), so the core is held cleared during reset.
- Throughput:
  - LOAD sustains 1 word/cycle.
  - DRAIN sustains 1 word/cycle with m_ready=1.
  - First m_valid appears 2 cycles after DRAIN entry.
- Minimum job latency, s_valid to last m_valid with no stalls: 1 (CLR) + 78 + core run + 1 + 79 cycles.
- Backpressure: m_data and m_last are held stable while m_valid=1 and m_ready=0. The FIFO never overflows.
- Async reset mid-job: the job is discarded, all outputs return to reset values immediately, and the core is cleared.

## Configuration
- RC_SCHED_TIMEOUT_EN defined:
  - A RUN cycle counter is active.
  - Reaching TIMEOUT_CYCLES without core_done → ABORT: core_enable=0, err set and sticky until reset, then → CLR if s_valid else IDLE.
  - No output words are produced for the aborted job.
- Undefined: no counter; RUN waits indefinitely; err is tied to 0.

## Structure
- Package rc_sched_pkg holds:
  - state enum
  - SLOT_WORDS and JOB_WORDS localparams
  - counter width localparam, $clog2(JOB_WORDS+1)
- One sub-module: rc_sched_out_fifo, a 2-entry N_BITS+1 FIFO (data + last) with occupancy output.

## Test plan
- 78 sequential words 1..78, m_ready=1, core model done 20 cycles after enable:
  - core_wr=01 for words 1–39, 10 for words 40–78
  - 78 outputs in slot order, m_last on the 78th
  - busy falls after the last pop
- s_last on word 5:
  - words 6..78 written as 0 during PAD, with s_ready=0
  - 78 outputs still produced
- m_ready toggling 1-0-0-1 during DRAIN:
  - no lost or duplicated word
  - FIFO occupancy never exceeds 2
- reset_n pulsed low during RUN:
  - all outputs return to reset values
  - core_reset=1 while reset_n is low
  - next job completes correctly
- With RC_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, core_done never asserted:
  - ABORT after 16 RUN cycles
  - err=1 and sticky, no m_valid
- Back-to-back jobs with s_valid held high:
  - second job's CLR follows IDLE by one cycle
  - no core_wr during the first job's DRAIN
